// File: rtl/enc_gray_conv_pipe.sv
// Two-stage valid/ready pipeline for Gray-code conversion.
// Modes: bin->gray, gray->bin, gray increment with wrap flag, and pass-through.
module enc_gray_conv_pipe #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_mode,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       out_mode,
    output logic             out_wrap
);

    localparam logic [1:0] MODE_B2G  = 2'b00;
    localparam logic [1:0] MODE_G2B  = 2'b01;
    localparam logic [1:0] MODE_GINC = 2'b10;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic             ready_en;
    logic             s1_valid;
    logic [1:0]       s1_mode;
    logic [WIDTH-1:0] s1_data;
    logic             s2_load;
    logic [WIDTH-1:0] conv_data;
    logic             conv_wrap;
    logic [WIDTH-1:0] inc_bin;

    function automatic logic [WIDTH-1:0] bin_to_gray(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [WIDTH-1:0] gray_to_bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Output stage frees up when empty or when its word leaves this cycle.
    assign s2_load  = !out_valid || out_ready;
    assign in_ready = ready_en && (!s1_valid || s2_load);

    always_comb begin
        conv_data = s1_data;
        conv_wrap = 1'b0;
        inc_bin   = gray_to_bin(s1_data);
        case (s1_mode)
            MODE_B2G:  conv_data = bin_to_gray(s1_data);
            MODE_G2B:  conv_data = inc_bin;
            MODE_GINC: begin
                conv_data = bin_to_gray(inc_bin + ONE);
                conv_wrap = &inc_bin;
            end
            default:   conv_data = s1_data;
        endcase
    end

    // Holds in_ready low until the first clock edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_mode  <= 2'b00;
            s1_data  <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_mode <= in_mode;
                s1_data <= in_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_mode  <= 2'b00;
            out_data  <= '0;
            out_wrap  <= 1'b0;
        end else if (s2_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_mode <= s1_mode;
                out_data <= conv_data;
                out_wrap <= conv_wrap;
            end
        end
    end

endmodule

// File: tb/tb_enc_gray_conv_pipe.sv
// Self-checking bench for enc_gray_conv_pipe (WIDTH=10) with a queue-based
// reference model computed from the Gray-code rules.
module tb_enc_gray_conv_pipe;

    localparam int W = 10;
    localparam int MAXV = (1 << W) - 1;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   in_mode;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic [1:0]   out_mode;
    logic         out_wrap;

    int n_cmp;
    int n_fail;

    enc_gray_conv_pipe #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_mode  (out_mode),
        .out_wrap  (out_wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Gray code of n is n XOR (n/2).
    function automatic int ref_b2g(input int n);
        return n ^ (n >> 1);
    endfunction

    // Binary bit i is the parity of all Gray bits at or above i.
    function automatic int ref_g2b(input int g);
        int b;
        b = 0;
        for (int i = 0; i < W; i++) begin
            int t;
            t = g >> i;
            if ($countones(t) % 2 == 1) b = b | (1 << i);
        end
        return b;
    endfunction

    // Packed as {wrap, mode[1:0], data[W-1:0]}.
    function automatic logic [W+2:0] ref_model(input int mode, input int d);
        int res;
        int wrap;
        int n;
        wrap = 0;
        case (mode)
            0: res = ref_b2g(d);
            1: res = ref_g2b(d);
            2: begin
                n    = ref_g2b(d);
                wrap = (n == MAXV) ? 1 : 0;
                res  = ref_b2g((n + 1) % (MAXV + 1));
            end
            default: res = d;
        endcase
        return {wrap[0], 2'(mode), W'(res)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_mode = 2'b00; in_data = '0; out_ready = 1'b0;
        #3;
        n_cmp++;
        if ({in_ready, out_valid, out_data, out_mode, out_wrap} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got rdy=%b ov=%b od=%h om=%b ow=%b required all 0",
                     in_ready, out_valid, out_data, out_mode, out_wrap);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL ready_before_edge: got %b required 0", in_ready);
        end
        tick();
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_after_edge: got %b required 1", in_ready);
        end
    endtask

    task automatic test_directed();
        int         tm [6] = '{0, 0, 1, 2, 2, 3};
        int         td [6] = '{'h005, 'h3FF, 'h200, 'h200, 'h000, 'h2A5};
        int         te [6] = '{'h007, 'h200, 'h3FF, 'h000, 'h001, 'h2A5};
        logic       tw [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        for (int k = 0; k < 6; k++) begin
            out_ready = 1'b1;
            in_valid  = 1'b1;
            in_mode   = 2'(tm[k]);
            in_data   = W'(td[k]);
            tick();
            in_valid = 1'b0;
            n_cmp++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL directed%0d_early: out_valid got %b required 0", k, out_valid);
            end
            tick();
            n_cmp++;
            if ({out_valid, out_data, out_mode, out_wrap} !== {1'b1, W'(te[k]), 2'(tm[k]), tw[k]}) begin
                n_fail++;
                $display("FAIL directed%0d: got v=%b d=%h m=%b w=%b required v=1 d=%h m=%0d w=%b",
                         k, out_valid, out_data, out_mode, out_wrap, te[k], tm[k], tw[k]);
            end
            tick();
        end
    endtask

    task automatic test_round_trip();
        logic [W-1:0] gstore [MAXV+1];
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < MAXV + 3; i++) begin
                out_ready = 1'b1;
                in_valid  = (i <= MAXV);
                in_mode   = 2'(p);
                in_data   = (i <= MAXV) ? ((p == 0) ? W'(i) : gstore[i]) : '0;
                tick();
                if (i >= 1 && i <= MAXV + 1) begin
                    n_cmp++;
                    if (p == 0) begin
                        if ({out_valid, out_data} !== {1'b1, W'(ref_b2g(i - 1))}) begin
                            n_fail++;
                            $display("FAIL b2g_sweep[%0d]: got v=%b d=%h required v=1 d=%h",
                                     i - 1, out_valid, out_data, ref_b2g(i - 1));
                        end
                        gstore[i-1] = out_data;
                    end else if ({out_valid, out_data} !== {1'b1, W'(i - 1)}) begin
                        n_fail++;
                        $display("FAIL round_trip[%0d]: got v=%b d=%h required v=1 d=%h",
                                 i - 1, out_valid, out_data, i - 1);
                    end
                end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [W+2:0] q[$];
        logic [W+2:0] held;
        logic [W+2:0] obs;
        logic         prev_hold;
        int           sent;
        int           cyc;
        int           drops;
        logic         exp_ready;
        sent = 0; cyc = 0; drops = 0; prev_hold = 1'b0; held = '0;
        while ((sent < 8 || q.size() > 0) && cyc < 100) begin
            in_valid  = (sent < 8);
            in_mode   = 2'($urandom_range(0, 3));
            in_data   = W'($urandom_range(0, MAXV));
            out_ready = !(cyc >= 3 && cyc < 8);
            #1;
            obs = {out_wrap, out_mode, out_data};
            if (prev_hold) begin
                n_cmp++;
                if (!out_valid || obs !== held) begin
                    n_fail++;
                    $display("FAIL b2b_stall_hold: got v=%b %h required v=1 %h", out_valid, obs, held);
                end
            end
            exp_ready = (q.size() < 2) || out_ready;
            n_cmp++;
            if (in_ready !== exp_ready) begin
                n_fail++;
                $display("FAIL b2b_in_ready cyc%0d: got %b required %b", cyc, in_ready, exp_ready);
            end
            if (!in_ready) drops++;
            if (out_valid) begin
                n_cmp++;
                if (q.size() == 0 || obs !== q[0]) begin
                    n_fail++;
                    $display("FAIL b2b_data: got %h required %h (queued %0d)",
                             obs, (q.size() > 0) ? q[0] : '0, q.size());
                end
                if (out_ready && q.size() > 0) void'(q.pop_front());
            end
            if (in_valid && in_ready) begin
                q.push_back(ref_model(in_mode, in_data));
                sent++;
            end
            prev_hold = out_valid && !out_ready;
            held      = obs;
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        n_cmp++;
        if (cyc >= 100 || drops == 0) begin
            n_fail++;
            $display("FAIL b2b_complete: cycles %0d stalls_seen %0d required <100 and >0", cyc, drops);
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_mode   = 2'b11;
        in_data   = W'('h155);
        tick();
        in_data = W'('h0AA);
        tick();
        in_valid = 1'b0;
        n_cmp++;
        if ({out_valid, in_ready} !== 2'b10) begin
            n_fail++;
            $display("FAIL full_before_reset: got v=%b rdy=%b required v=1 rdy=0", out_valid, in_ready);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({out_valid, in_ready, out_data, out_mode, out_wrap} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got v=%b rdy=%b d=%h m=%b w=%b required all 0",
                     out_valid, in_ready, out_data, out_mode, out_wrap);
        end
        tick();
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_cmp++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL stale_after_reset cyc%0d: out_valid got %b required 0", i, out_valid);
            end
        end
    endtask

    task automatic test_random();
        logic [W+2:0] q[$];
        logic [W+2:0] held;
        logic [W+2:0] obs;
        logic         prev_hold;
        logic         exp_ready;
        int           sent;
        int           cyc;
        sent = 0; cyc = 0; prev_hold = 1'b0; held = '0;
        while ((sent < 10000 || q.size() > 0) && cyc < 60000) begin
            in_valid  = (sent < 10000) && ($urandom_range(0, 9) < 7);
            in_mode   = 2'($urandom_range(0, 3));
            in_data   = W'($urandom_range(0, MAXV));
            out_ready = ($urandom_range(0, 9) < 6);
            #1;
            obs = {out_wrap, out_mode, out_data};
            if (prev_hold) begin
                n_cmp++;
                if (!out_valid || obs !== held) begin
                    n_fail++;
                    $display("FAIL rnd_stall_hold cyc%0d: got v=%b %h required v=1 %h",
                             cyc, out_valid, obs, held);
                end
            end
            exp_ready = (q.size() < 2) || out_ready;
            n_cmp++;
            if (in_ready !== exp_ready) begin
                n_fail++;
                $display("FAIL rnd_in_ready cyc%0d: got %b required %b", cyc, in_ready, exp_ready);
            end
            if (out_valid) begin
                n_cmp++;
                if (q.size() == 0 || obs !== q[0]) begin
                    n_fail++;
                    $display("FAIL rnd_data cyc%0d: got %h required %h (queued %0d)",
                             cyc, obs, (q.size() > 0) ? q[0] : '0, q.size());
                end
                if (out_ready && q.size() > 0) void'(q.pop_front());
            end
            if (in_valid && in_ready) begin
                q.push_back(ref_model(in_mode, in_data));
                sent++;
            end
            prev_hold = out_valid && !out_ready;
            held      = obs;
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        n_cmp++;
        if (cyc >= 60000) begin
            n_fail++;
            $display("FAIL rnd_timeout: sent %0d pending %0d required all drained", sent, q.size());
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        test_reset();
        test_directed();
        test_round_trip();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/enc_gray_conv_pipe.md
ENC_GRAY_CONV_PIPE -- requirements
Module: enc_gray_conv_pipe

Interface
REQ-001: Parameter WIDTH, default 10, data width in bits; legal range 2..32.
REQ-002: clk  input  1  single clock; all state updates on rising edge.
REQ-003: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004: in_valid  input  1  input word and mode present.
REQ-005: in_ready  output  1  block accepts input this cycle.
REQ-006: in_mode  input  2  operation: 00 bin->gray, 01 gray->bin, 10 gray increment, 11 pass-through.
REQ-007: in_data  input  WIDTH  operand.
REQ-008: out_valid  output  1  result present.
REQ-009: out_ready  input  1  downstream accepts result.
REQ-010: out_data  output  WIDTH  result.
REQ-011: out_mode  output  2  in_mode that produced out_data.
REQ-012: out_wrap  output  1  gray-increment result wrapped from all-ones binary to zero; 0 in other modes.

Function
REQ-013: Transfer occurs on a rising edge when valid and ready are both high; no transfer otherwise.
REQ-014: Two-stage pipeline: stage 1 registers in_data/in_mode; stage 2 registers converted result, out_mode, out_wrap.
REQ-015: Latency exactly 2 cycles from input transfer to out_valid with no backpressure; throughput one word per cycle.
REQ-016: Stage 2 loads when empty or its output transfers in the same cycle; stage 1 loads when empty or stage 1 advances in the same cycle.
REQ-017: in_ready = NOT s1_valid OR s1 advancing this cycle; no combinational path from in_valid to in_ready.
REQ-018: Stalled output holds out_data, out_mode, out_wrap, out_valid stable until transfer.
REQ-019: Simultaneous input transfer and output transfer with both stages full: no word lost or duplicated; ordering preserved.
REQ-020: bin->gray: g[WIDTH-1] = b[WIDTH-1]; g[i] = b[i+1] XOR b[i] for i < WIDTH-1.
REQ-021: gray->bin: b[WIDTH-1] = g[WIDTH-1]; b[i] = b[i+1] XOR g[i] (prefix XOR from MSB).
REQ-022: gray increment: convert operand to binary, add 1 modulo 2^WIDTH, convert back to gray; out_wrap = 1 iff binary operand was all ones.
REQ-023: pass-through: out_data = in_data unchanged.
REQ-024: All arithmetic WIDTH bits, unsigned, carry discarded except as out_wrap.
REQ-025: Conversion logic between stage 1 and stage 2 only; out_data driven directly from registers.

Reset
REQ-026: rst_n low asynchronously clears s1_valid, s2_valid, out_valid to 0; out_data, out_mode, out_wrap to 0.
REQ-027: in_ready is 0 while rst_n is low, and 1 from the first clock edge after rst_n deasserts.
REQ-028: Reset mid-operation discards all in-flight words; no output produced for them after release.
REQ-029: rst_n deassertion is synchronised externally; block needs no internal reset synchroniser.

Verification (WIDTH=10)
REQ-030: mode 00, in_data 0x005, out_ready=1 -> 2 cycles later out_data 0x007, out_mode 00, out_wrap 0.
REQ-031: mode 00 in 0x3FF -> out 0x200; mode 01 in 0x200 -> out 0x3FF; exhaustive 0..0x3FF round trip (00 then 01) returns original.
REQ-032: mode 10 in 0x200 (binary 1023) -> out 0x000, out_wrap 1; mode 10 in 0x000 -> out 0x001, out_wrap 0.
REQ-033: back-to-back 8 words, out_ready held 0 for 5 cycles mid-stream -> in_ready drops after 2 words buffered, output order and values intact, no loss/duplication.
REQ-034: rst_n pulsed low with both stages full -> out_valid 0 immediately (asynchronous); no stale word emitted after release.
REQ-035: random valid/ready toggling, all modes, 10k words vs reference model -> zero mismatches; out_data stable during every stall.
